// File: rtl/mult_mant_seq.sv
// Sequential shift-add mantissa multiplier for the FPU multiply path.
// Produces the raw hidden-bit product, biased exponent sum and sign for the normalize stage.
module mult_mant_seq #(
    parameter int EXPSIZE  = 8,
    parameter int MANTSIZE = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    a_sign,
    input  logic [EXPSIZE-1:0]      a_exp,
    input  logic [MANTSIZE-1:0]     a_mant,
    input  logic                    b_sign,
    input  logic [EXPSIZE-1:0]      b_exp,
    input  logic [MANTSIZE-1:0]     b_mant,
    output logic                    busy,
    output logic                    done,
    output logic                    out_sign,
    output logic [EXPSIZE-1:0]      out_exp,
    output logic [2*MANTSIZE+1:0]   out_mant,
    output logic                    zero,
    output logic                    ovf,
    output logic                    uf
);

    localparam int W  = MANTSIZE + 1;
    localparam int PW = 2 * W;
    localparam int EW = EXPSIZE + 2;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXPSIZE - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXPSIZE) - 2);
    localparam logic signed [EW-1:0] EXP_MIN = EW'(1);

    typedef enum logic {
        IDLE = 1'b0,
        MULT = 1'b1
    } state_t;

    // Denormals (stored exponent 0) behave as exponent 1 with no hidden bit.
    function automatic logic signed [EW-1:0] eff_exp(input logic [EXPSIZE-1:0] e);
        logic signed [EW-1:0] r;
        r = (e == '0) ? EXP_MIN : $signed({2'b00, e});
        return r;
    endfunction

    function automatic logic [EXPSIZE-1:0] sat_exp(input logic signed [EW-1:0] e);
        logic [EXPSIZE-1:0] r;
        if (e > EXP_MAX) begin
            r = '1;
        end else if (e < EXP_MIN) begin
            r = '0;
        end else begin
            r = e[EXPSIZE-1:0];
        end
        return r;
    endfunction

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   last;
    logic                   load;

    logic [W-1:0]           a_q;
    logic [PW-1:0]          p_q;
    logic                   sign_q;
    logic signed [EW-1:0]   exp_q;
    logic                   zero_q;

    logic                   done_q;
    logic                   out_sign_q;
    logic [EXPSIZE-1:0]     out_exp_q;
    logic [PW-1:0]          out_mant_q;
    logic                   zero_out_q;
    logic                   ovf_q;
    logic                   uf_q;

    logic [W-1:0]           mant_a_full;
    logic [W-1:0]           mant_b_full;
    logic signed [EW-1:0]   exp_sum;
    logic [W:0]             addend;
    logic [W:0]             sum;
    logic [PW-1:0]          p_shift;

    // Capture-time decode of the incoming operands.
    always_comb begin
        mant_a_full = {(a_exp != '0), a_mant};
        mant_b_full = {(b_exp != '0), b_mant};
        exp_sum     = eff_exp(a_exp) + eff_exp(b_exp) - BIAS;
    end

    // One shift-add step: the carry out of the upper half becomes the new MSB.
    always_comb begin
        addend  = p_q[0] ? {1'b0, a_q} : '0;
        sum     = {1'b0, p_q[PW-1:W]} + addend;
        p_shift = {sum, p_q[W-1:1]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last    = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = MULT;
                end
            end
            MULT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    last    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand and product registers carry data only and need no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            a_q    <= mant_a_full;
            p_q    <= {{W{1'b0}}, mant_b_full};
            sign_q <= a_sign ^ b_sign;
            exp_q  <= exp_sum;
            zero_q <= (mant_a_full == '0) || (mant_b_full == '0);
        end else if (state_q == MULT) begin
            p_q <= p_shift;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q     <= 1'b0;
            out_sign_q <= 1'b0;
            out_exp_q  <= '0;
            out_mant_q <= '0;
            zero_out_q <= 1'b0;
            ovf_q      <= 1'b0;
            uf_q       <= 1'b0;
        end else begin
            done_q <= last;
            if (last) begin
                out_sign_q <= sign_q;
                zero_out_q <= zero_q;
                out_mant_q <= zero_q ? '0 : p_shift;
                out_exp_q  <= zero_q ? '0 : sat_exp(exp_q);
                ovf_q      <= !zero_q && (exp_q > EXP_MAX);
                uf_q       <= !zero_q && (exp_q < EXP_MIN);
            end
        end
    end

    assign busy     = (state_q == MULT);
    assign done     = done_q;
    assign out_sign = out_sign_q;
    assign out_exp  = out_exp_q;
    assign out_mant = out_mant_q;
    assign zero     = zero_out_q;
    assign ovf      = ovf_q;
    assign uf       = uf_q;

endmodule

// File: tb/tb_mult_mant_seq.sv
// Directed, table-driven bench for mult_mant_seq at the default 8/23 configuration.
module tb_mult_mant_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        a_sign = 1'b0, b_sign = 1'b0;
    logic [7:0]  a_exp = '0, b_exp = '0;
    logic [22:0] a_mant = '0, b_mant = '0;
    logic        busy, done, out_sign, zero, ovf, uf;
    logic [7:0]  out_exp;
    logic [47:0] out_mant;

    int checks = 0;
    int failures = 0;

    mult_mant_seq #(.EXPSIZE(8), .MANTSIZE(23)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_sign(a_sign), .a_exp(a_exp), .a_mant(a_mant),
        .b_sign(b_sign), .b_exp(b_exp), .b_mant(b_mant),
        .busy(busy), .done(done), .out_sign(out_sign), .out_exp(out_exp),
        .out_mant(out_mant), .zero(zero), .ovf(ovf), .uf(uf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        as;
        logic [7:0]  ae;
        logic [22:0] am;
        logic        bs;
        logic [7:0]  be;
        logic [22:0] bm;
        logic        es;
        logic [7:0]  ee;
        logic [47:0] em;
        logic [2:0]  ef;   // {zero, ovf, uf}
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        a_sign = v.as; a_exp = v.ae; a_mant = v.am;
        b_sign = v.bs; b_exp = v.be; b_mant = v.bm;
    endtask

    task automatic check_result(input string tag, input vec_t v);
        check({tag, "_mant"}, 64'(out_mant), 64'(v.em));
        check({tag, "_exp"}, 64'(out_exp), 64'(v.ee));
        check({tag, "_sign"}, 64'(out_sign), 64'(v.es));
        check({tag, "_flags"}, 64'({zero, ovf, uf}), 64'(v.ef));
    endtask

    // Counts edges until done is seen, bounded at 40.
    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
        end while (!done && cycles < 40);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int c;
        @(negedge clk);
        drive(v);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done(c);
        check({tag, "_latency"}, 64'(c), 64'd24);
        check_result(tag, v);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int c;
        int seen;
        //          as ae     am          bs be     bm          es ee     em                  ef
        vecs[0]  = '{1'b0, 8'd127, 23'h400000, 1'b0, 8'd128, 23'h000000, 1'b0, 8'd128, 48'h6000_0000_0000, 3'b000};
        vecs[1]  = '{1'b0, 8'd127, 23'h400000, 1'b1, 8'd127, 23'h400000, 1'b1, 8'd127, 48'h9000_0000_0000, 3'b000};
        vecs[2]  = '{1'b0, 8'd254, 23'h000000, 1'b0, 8'd254, 23'h000000, 1'b0, 8'hFF,  48'h4000_0000_0000, 3'b010};
        vecs[3]  = '{1'b0, 8'd1,   23'h000000, 1'b0, 8'd1,   23'h000000, 1'b0, 8'h00,  48'h4000_0000_0000, 3'b001};
        vecs[4]  = '{1'b0, 8'd0,   23'h000000, 1'b1, 8'd130, 23'h123456, 1'b1, 8'h00,  48'h0,              3'b100};
        vecs[5]  = '{1'b0, 8'd0,   23'h000001, 1'b0, 8'd127, 23'h000000, 1'b0, 8'd1,   48'h0000_0080_0000, 3'b000};
        vecs[6]  = '{1'b1, 8'd127, 23'h7FFFFF, 1'b1, 8'd127, 23'h7FFFFF, 1'b0, 8'd127, 48'hFFFF_FE00_0001, 3'b000};
        vecs[7]  = '{1'b0, 8'd200, 23'h000000, 1'b0, 8'd181, 23'h000000, 1'b0, 8'hFE,  48'h4000_0000_0000, 3'b000};
        vecs[8]  = '{1'b0, 8'd200, 23'h000000, 1'b0, 8'd182, 23'h000000, 1'b0, 8'hFF,  48'h4000_0000_0000, 3'b010};
        vecs[9]  = '{1'b0, 8'd64,  23'h000000, 1'b0, 8'd64,  23'h000000, 1'b0, 8'd1,   48'h4000_0000_0000, 3'b000};
        vecs[10] = '{1'b0, 8'd64,  23'h000000, 1'b0, 8'd63,  23'h000000, 1'b0, 8'h00,  48'h4000_0000_0000, 3'b001};
        vecs[11] = '{1'b0, 8'd254, 23'h000000, 1'b1, 8'd0,   23'h000000, 1'b1, 8'h00,  48'h0,              3'b100};
        vecs[12] = '{1'b0, 8'd130, 23'h200000, 1'b0, 8'd125, 23'h600000, 1'b0, 8'd128, 48'h8C00_0000_0000, 3'b000};

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_outs", 64'({out_sign, out_exp, zero, ovf, uf}), 64'd0);
        check("rst_mant", 64'(out_mant), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Start while busy is ignored; operands changed after capture must not leak in
        @(negedge clk);
        drive(vecs[0]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        drive(vecs[6]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ign_busy", 64'(busy), 64'd1);
        wait_done(c);
        check("ign_latency", 64'(c + 5), 64'd24);
        check_result("ign", vecs[0]);

        // Back-to-back: start in the done cycle
        drive(vecs[1]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_done_drop", 64'(done), 64'd0);
        wait_done(c);
        check("b2b_interval", 64'(c + 1), 64'd25);
        check_result("b2b", vecs[1]);

        // Asynchronous reset mid-operation
        @(negedge clk);
        drive(vecs[6]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_outs", 64'({out_sign, out_exp, zero, ovf, uf}), 64'd0);
        check("arst_mant", 64'(out_mant), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1;
        end
        check("arst_no_done", 64'(seen), 64'd0);
        run_vec("post_rst", vecs[12]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
